mag_compare_checker: RTL and testbench

MAG_COMPARE_CHECKER -- requirements
Module: mag_compare_checker

---
 rtl/mag_compare_checker.sv | 166 ++++++++++++++++
 tb/tb_mag_compare_checker.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mag_compare_checker.sv
// Two-stage checker for a WIDTH-bit magnitude comparator: registers observed flags, recomputes them, reports mismatches.
// Define CMP_CHECK_HALT_EN to make the first mismatch stop acceptance until clr.
module mag_compare_checker #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             eq,
    input  logic             gt,
    input  logic             lt,
    input  logic             clr,
    output logic             err_valid,
    output logic [2:0]       err_exp,
    output logic [2:0]       err_got,
    output logic [15:0]      chk_cnt,
    output logic [7:0]       err_cnt,
    output logic [WIDTH-1:0] first_a,
    output logic [WIDTH-1:0] first_b,
    output logic             halted
);

    logic             accept;
    logic             mismatch;
    logic [2:0]       exp_flags;

    logic             s1_vld_q, s1_vld_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [2:0]       s1_got_q, s1_got_d;

    logic             err_valid_q, err_valid_d;
    logic [2:0]       err_exp_q, err_exp_d;
    logic [2:0]       err_got_q, err_got_d;
    logic [15:0]      chk_cnt_q, chk_cnt_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic [WIDTH-1:0] first_a_q, first_a_d;
    logic [WIDTH-1:0] first_b_q, first_b_d;
    logic             seen_q, seen_d;

    // clr wins over a same-cycle acceptance, which is simply dropped
    assign accept    = in_valid && in_ready && !clr;
    assign exp_flags = {s1_a_q == s1_b_q, s1_a_q > s1_b_q, s1_a_q < s1_b_q};
    assign mismatch  = s1_vld_q && (exp_flags != s1_got_q);

    always_comb begin
        s1_vld_d = accept;
        s1_a_d   = s1_a_q;
        s1_b_d   = s1_b_q;
        s1_got_d = s1_got_q;
        if (accept) begin
            s1_a_d   = a;
            s1_b_d   = b;
            s1_got_d = {eq, gt, lt};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            s1_got_q <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s1_a_q   <= s1_a_d;
            s1_b_q   <= s1_b_d;
            s1_got_q <= s1_got_d;
        end
    end

    always_comb begin
        err_valid_d = mismatch;
        err_exp_d   = err_exp_q;
        err_got_d   = err_got_q;
        chk_cnt_d   = s1_vld_q ? chk_cnt_q + 16'd1 : chk_cnt_q;
        err_cnt_d   = (mismatch && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
        first_a_d   = first_a_q;
        first_b_d   = first_b_q;
        seen_d      = seen_q;
        if (mismatch) begin
            err_exp_d = exp_flags;
            err_got_d = s1_got_q;
            if (!seen_q) begin
                first_a_d = s1_a_q;
                first_b_d = s1_b_q;
                seen_d    = 1'b1;
            end
        end
        // flush without reporting; err_exp/err_got keep their last values
        if (clr) begin
            err_valid_d = 1'b0;
            chk_cnt_d   = '0;
            err_cnt_d   = '0;
            first_a_d   = '0;
            first_b_d   = '0;
            seen_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_valid_q <= 1'b0;
            err_exp_q   <= '0;
            err_got_q   <= '0;
            chk_cnt_q   <= '0;
            err_cnt_q   <= '0;
            first_a_q   <= '0;
            first_b_q   <= '0;
            seen_q      <= 1'b0;
        end else begin
            err_valid_q <= err_valid_d;
            err_exp_q   <= err_exp_d;
            err_got_q   <= err_got_d;
            chk_cnt_q   <= chk_cnt_d;
            err_cnt_q   <= err_cnt_d;
            first_a_q   <= first_a_d;
            first_b_q   <= first_b_d;
            seen_q      <= seen_d;
        end
    end

    assign err_valid = err_valid_q;
    assign err_exp   = err_exp_q;
    assign err_got   = err_got_q;
    assign chk_cnt   = chk_cnt_q;
    assign err_cnt   = err_cnt_q;
    assign first_a   = first_a_q;
    assign first_b   = first_b_q;

`ifdef CMP_CHECK_HALT_EN
    typedef enum logic {
        RUN,
        HALT
    } state_e;

    state_e state_q, state_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (!clr && mismatch) state_d = HALT;
            HALT:    if (clr) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign in_ready = rst_n && (state_q == RUN);
    assign halted   = (state_q == HALT);
`else
    assign in_ready = rst_n;
    assign halted   = 1'b0;
`endif

endmodule

// File: tb/tb_mag_compare_checker.sv
// Directed self-checking bench for mag_compare_checker; expected values worked out by hand per vector.
// Halt-dependent expectations follow CMP_CHECK_HALT_EN.
module tb_mag_compare_checker;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  a;
    logic [3:0]  b;
    logic        eq;
    logic        gt;
    logic        lt;
    logic        clr;
    logic        err_valid;
    logic [2:0]  err_exp;
    logic [2:0]  err_got;
    logic [15:0] chk_cnt;
    logic [7:0]  err_cnt;
    logic [3:0]  first_a;
    logic [3:0]  first_b;
    logic        halted;

    int checks = 0;
    int errors = 0;

    mag_compare_checker #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .eq       (eq),
        .gt       (gt),
        .lt       (lt),
        .clr      (clr),
        .err_valid(err_valid),
        .err_exp  (err_exp),
        .err_got  (err_got),
        .chk_cnt  (chk_cnt),
        .err_cnt  (err_cnt),
        .first_a  (first_a),
        .first_b  (first_b),
        .halted   (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive(input logic [3:0] av, input logic [3:0] bv, input logic [2:0] fl);
        a = av;
        b = bv;
        {eq, gt, lt} = fl;
        in_valid = 1'b1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        idle();
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL rst_err_valid got %0b exp 0", err_valid); end
        checks++; if (err_exp !== 3'b000 || err_got !== 3'b000) begin errors++; $display("FAIL rst_err_flags got %b/%b exp 000/000", err_exp, err_got); end
        checks++; if (chk_cnt !== 16'd0 || err_cnt !== 8'd0) begin errors++; $display("FAIL rst_counts got %0d/%0d exp 0/0", chk_cnt, err_cnt); end
        checks++; if (first_a !== 4'd0 || first_b !== 4'd0) begin errors++; $display("FAIL rst_first got %0d/%0d exp 0/0", first_a, first_b); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %0b exp 0", halted); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %0b exp 1", in_ready); end
    endtask

    task automatic test_match();
        drive(4'd5, 4'd5, 3'b100);
        @(negedge clk);
        idle();
        checks++; if (chk_cnt !== 16'd0) begin errors++; $display("FAIL match_latency1 got %0d exp 0", chk_cnt); end
        @(negedge clk);
        checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL match_err_valid got %0b exp 0", err_valid); end
        checks++; if (chk_cnt !== 16'd1) begin errors++; $display("FAIL match_chk_cnt got %0d exp 1", chk_cnt); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL match_err_cnt got %0d exp 0", err_cnt); end
    endtask

    task automatic test_mismatch();
        do_clr();
        checks++; if (chk_cnt !== 16'd0) begin errors++; $display("FAIL clr_chk_cnt got %0d exp 0", chk_cnt); end
        drive(4'd3, 4'd9, 3'b000);
        @(negedge clk);
        idle();
        checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL mis_early got %0b exp 0", err_valid); end
        @(negedge clk);
        checks++; if (err_valid !== 1'b1) begin errors++; $display("FAIL mis_err_valid got %0b exp 1", err_valid); end
        checks++; if (err_exp !== 3'b001 || err_got !== 3'b000) begin errors++; $display("FAIL mis_flags got %b/%b exp 001/000", err_exp, err_got); end
        checks++; if (err_cnt !== 8'd1 || chk_cnt !== 16'd1) begin errors++; $display("FAIL mis_counts got %0d/%0d exp 1/1", err_cnt, chk_cnt); end
        checks++; if (first_a !== 4'd3 || first_b !== 4'd9) begin errors++; $display("FAIL mis_first got %0d/%0d exp 3/9", first_a, first_b); end
        @(negedge clk);
        checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL mis_pulse_end got %0b exp 0", err_valid); end
        checks++; if (err_exp !== 3'b001 || err_got !== 3'b000) begin errors++; $display("FAIL mis_hold got %b/%b exp 001/000", err_exp, err_got); end
    endtask

    task automatic test_back_to_back();
        do_clr();
        drive(4'd12, 4'd7, 3'b010);
        @(negedge clk);
        drive(4'd0, 4'd15, 3'b000);
        @(negedge clk);
        idle();
        checks++; if (err_valid !== 1'b0 || chk_cnt !== 16'd1) begin errors++; $display("FAIL b2b_first got ev=%0b cnt=%0d exp ev=0 cnt=1", err_valid, chk_cnt); end
        @(negedge clk);
        checks++; if (err_valid !== 1'b1) begin errors++; $display("FAIL b2b_err_valid got %0b exp 1", err_valid); end
        checks++; if (err_exp !== 3'b001 || err_got !== 3'b000) begin errors++; $display("FAIL b2b_flags got %b/%b exp 001/000", err_exp, err_got); end
        checks++; if (chk_cnt !== 16'd2 || err_cnt !== 8'd1) begin errors++; $display("FAIL b2b_counts got %0d/%0d exp 2/1", chk_cnt, err_cnt); end
        checks++; if (first_a !== 4'd0 || first_b !== 4'd15) begin errors++; $display("FAIL b2b_first_ab got %0d/%0d exp 0/15", first_a, first_b); end
        @(negedge clk);
        checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL b2b_pulse_end got %0b exp 0", err_valid); end
    endtask

    task automatic test_non_one_hot();
        do_clr();
        drive(4'd5, 4'd5, 3'b111);
        @(negedge clk);
        drive(4'd2, 4'd7, 3'b011);
        @(negedge clk);
        idle();
        checks++; if (err_valid !== 1'b1 || err_exp !== 3'b100 || err_got !== 3'b111) begin errors++; $display("FAIL noh_111 got ev=%0b %b/%b exp ev=1 100/111", err_valid, err_exp, err_got); end
        checks++; if (first_a !== 4'd5 || first_b !== 4'd5) begin errors++; $display("FAIL noh_first got %0d/%0d exp 5/5", first_a, first_b); end
        @(negedge clk);
        checks++; if (err_valid !== 1'b1 || err_exp !== 3'b001 || err_got !== 3'b011) begin errors++; $display("FAIL noh_011 got ev=%0b %b/%b exp ev=1 001/011", err_valid, err_exp, err_got); end
        checks++; if (err_cnt !== 8'd2 || chk_cnt !== 16'd2) begin errors++; $display("FAIL noh_counts got %0d/%0d exp 2/2", err_cnt, chk_cnt); end
        checks++; if (first_a !== 4'd5 || first_b !== 4'd5) begin errors++; $display("FAIL noh_first_hold got %0d/%0d exp 5/5", first_a, first_b); end
    endtask

    task automatic test_clr_priority();
        do_clr();
        drive(4'd3, 4'd9, 3'b000);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        idle();
        @(negedge clk);
        checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL clrpri_err_valid got %0b exp 0", err_valid); end
        checks++; if (chk_cnt !== 16'd0 || err_cnt !== 8'd0) begin errors++; $display("FAIL clrpri_counts got %0d/%0d exp 0/0", chk_cnt, err_cnt); end
    endtask

    task automatic test_halt();
        logic [15:0] exp_cnt_end;
        logic        exp_halt;
`ifdef CMP_CHECK_HALT_EN
        exp_cnt_end = 16'd2;
        exp_halt    = 1'b1;
`else
        exp_cnt_end = 16'd4;
        exp_halt    = 1'b0;
`endif
        do_clr();
        drive(4'd3, 4'd9, 3'b000);
        @(negedge clk);
        drive(4'd5, 4'd5, 3'b100);
        @(negedge clk);
        drive(4'd1, 4'd2, 3'b001);
        checks++; if (halted !== exp_halt || in_ready !== !exp_halt) begin errors++; $display("FAIL halt_state got h=%0b r=%0b exp h=%0b r=%0b", halted, in_ready, exp_halt, !exp_halt); end
        checks++; if (err_valid !== 1'b1 || chk_cnt !== 16'd1) begin errors++; $display("FAIL halt_err got ev=%0b cnt=%0d exp ev=1 cnt=1", err_valid, chk_cnt); end
        @(negedge clk);
        drive(4'd4, 4'd4, 3'b100);
        checks++; if (chk_cnt !== 16'd2 || err_valid !== 1'b0) begin errors++; $display("FAIL halt_inflight got cnt=%0d ev=%0b exp cnt=2 ev=0", chk_cnt, err_valid); end
        @(negedge clk);
        idle();
        @(negedge clk);
        checks++; if (chk_cnt !== exp_cnt_end || err_cnt !== 8'd1) begin errors++; $display("FAIL halt_end_counts got %0d/%0d exp %0d/1", chk_cnt, err_cnt, exp_cnt_end); end
        checks++; if (halted !== exp_halt || in_ready !== !exp_halt) begin errors++; $display("FAIL halt_persist got h=%0b r=%0b exp h=%0b", halted, in_ready, exp_halt); end
        drive(4'd6, 4'd6, 3'b100);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        idle();
        checks++; if (halted !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL halt_clr_state got h=%0b r=%0b exp h=0 r=1", halted, in_ready); end
        checks++; if (chk_cnt !== 16'd0 || err_cnt !== 8'd0 || first_a !== 4'd0 || first_b !== 4'd0) begin errors++; $display("FAIL halt_clr_zero got %0d/%0d/%0d/%0d exp 0/0/0/0", chk_cnt, err_cnt, first_a, first_b); end
        @(negedge clk);
        checks++; if (chk_cnt !== 16'd0) begin errors++; $display("FAIL halt_clr_drop got %0d exp 0", chk_cnt); end
    endtask

`ifndef CMP_CHECK_HALT_EN
    task automatic test_saturate();
        do_clr();
        for (int i = 0; i < 256; i++) begin
            drive(4'd15, 4'd0, 3'b000);
            @(negedge clk);
        end
        idle();
        @(negedge clk);
        checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL sat_err_cnt got %0d exp 255", err_cnt); end
        checks++; if (chk_cnt !== 16'd256) begin errors++; $display("FAIL sat_chk_cnt got %0d exp 256", chk_cnt); end
        checks++; if (first_a !== 4'd15 || first_b !== 4'd0) begin errors++; $display("FAIL sat_first got %0d/%0d exp 15/0", first_a, first_b); end
    endtask
`endif

    task automatic test_reset_midpipe();
        do_clr();
        drive(4'd3, 4'd9, 3'b000);
        @(negedge clk);
        drive(4'd4, 4'd9, 3'b000);
        @(negedge clk);
        idle();
        checks++; if (err_valid !== 1'b1 || err_cnt !== 8'd1) begin errors++; $display("FAIL rmp_pre got ev=%0b cnt=%0d exp ev=1 cnt=1", err_valid, err_cnt); end
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL rmp_err_valid got %0b exp 0", err_valid); end
        checks++; if (err_exp !== 3'b000 || err_got !== 3'b000) begin errors++; $display("FAIL rmp_flags got %b/%b exp 000/000", err_exp, err_got); end
        checks++; if (chk_cnt !== 16'd0 || err_cnt !== 8'd0) begin errors++; $display("FAIL rmp_counts got %0d/%0d exp 0/0", chk_cnt, err_cnt); end
        checks++; if (first_a !== 4'd0 || first_b !== 4'd0) begin errors++; $display("FAIL rmp_first got %0d/%0d exp 0/0", first_a, first_b); end
        checks++; if (halted !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rmp_state got h=%0b r=%0b exp h=0 r=1", halted, in_ready); end
        @(negedge clk);
        checks++; if (err_valid !== 1'b0 || chk_cnt !== 16'd0) begin errors++; $display("FAIL rmp_late got ev=%0b cnt=%0d exp ev=0 cnt=0", err_valid, chk_cnt); end
    endtask

    initial begin
        in_valid = 1'b0;
        clr      = 1'b0;
        a        = '0;
        b        = '0;
        eq       = 1'b0;
        gt       = 1'b0;
        lt       = 1'b0;
        test_reset();
        test_match();
        test_mismatch();
        test_back_to_back();
        test_non_one_hot();
        test_clr_priority();
        test_halt();
`ifndef CMP_CHECK_HALT_EN
        test_saturate();
`endif
        test_reset_midpipe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
